// File: rtl/timer_pkg.sv
// Shared register map, bit positions and FSM encoding for the CPU timer block.
package timer_pkg;

   localparam logic [1:0] ADDR_CTRL = 2'd0;
   localparam logic [1:0] ADDR_CMP  = 2'd1;
   localparam logic [1:0] ADDR_CNT  = 2'd2;
   localparam logic [1:0] ADDR_STAT = 2'd3;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_PER  = 1;
   localparam int CTRL_IE   = 2;
   localparam int STAT_PEND = 0;
   localparam int STAT_OVR  = 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FIRED = 2'd2;

   localparam int unsigned DEF_PRESCALE = 100000;

   typedef struct packed {
      logic ie;
      logic periodic;
      logic en;
   } ctrl_t;

endpackage

// File: rtl/timer_tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE clocks while run is high.
module timer_tick_gen
   import timer_pkg::*;
#(
   parameter int unsigned PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic tick
);

   localparam int unsigned PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] ONE  = PW'(1);

   logic [PW-1:0] pre_q, pre_d;

   assign tick = run && (pre_q == LAST);

   always_comb begin
      pre_d = pre_q;
      if (clr || tick) begin
         pre_d = '0;
      end else if (run) begin
         pre_d = pre_q + ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/timer_irq_ctrl.sv
// MMIO timer: tick counter with compare, one-shot/periodic modes and a level
// interrupt cleared by acknowledge or write-1-to-clear.
module timer_irq_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned PRESCALE = DEF_PRESCALE,
   parameter int unsigned CNT_W    = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic        re,
   input  logic [1:0]  addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   input  logic        int_ack,
   output logic        INT
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic [CNT_W-1:0] cmp_q, cmp_d, cnt_q, cnt_d, cnt_nxt;
   logic             pend_q, pend_d, ovr_q, ovr_d, int_q, int_d;
   logic [31:0]      dout_q, dout_d, rdata;
   logic             tick, pre_clr, fire, pend_clr;
   logic             ctrl_wr, cmp_wr, cnt_wr, stat_wr;

   assign ctrl_wr = we && (addr == ADDR_CTRL);
   assign cmp_wr  = we && (addr == ADDR_CMP);
   assign cnt_wr  = we && (addr == ADDR_CNT);
   assign stat_wr = we && (addr == ADDR_STAT);
   assign cnt_nxt = cnt_q + CNT_ONE;

   // Prescaler restarts on a COUNT write and whenever RUN is entered or left.
   assign pre_clr = cnt_wr || ((state_q == ST_RUN) != (state_d == ST_RUN));

   timer_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .run  (state_q == ST_RUN),
      .clr  (pre_clr),
      .tick (tick)
   );

   // Tick uses the old CTRL; a CTRL write then decides the state transition.
   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      cmp_d   = cmp_q;
      cnt_d   = cnt_q;
      fire    = 1'b0;
      if (state_q == ST_RUN && tick && !cnt_wr) begin
         if (cmp_q != '0 && cnt_nxt >= cmp_q) begin
            fire = 1'b1;
            if (ctrl_q.periodic) begin
               cnt_d = '0;
            end else begin
               cnt_d   = cnt_nxt;
               state_d = ST_FIRED;
            end
         end else begin
            cnt_d = cnt_nxt;
         end
      end
      if (cnt_wr) cnt_d = '0;
      if (cmp_wr) cmp_d = data_in[CNT_W-1:0];
      if (ctrl_wr) begin
         ctrl_d.en       = data_in[CTRL_EN];
         ctrl_d.periodic = data_in[CTRL_PER];
         ctrl_d.ie       = data_in[CTRL_IE];
         case (state_q)
            ST_IDLE:  if (data_in[CTRL_EN]) state_d = ST_RUN;
            ST_RUN:   if (!data_in[CTRL_EN]) state_d = ST_IDLE;
            ST_FIRED: begin
               state_d = data_in[CTRL_EN] ? ST_RUN : ST_IDLE;
               if (data_in[CTRL_EN]) cnt_d = '0;
            end
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Set beats clear for both PEND and OVR.
   assign pend_clr = int_ack || (stat_wr && data_in[STAT_PEND]);

   always_comb begin
      pend_d = pend_q;
      ovr_d  = ovr_q;
      if (fire) pend_d = 1'b1;
      else if (pend_clr) pend_d = 1'b0;
      if (fire && pend_q) ovr_d = 1'b1;
      else if (stat_wr && data_in[STAT_OVR]) ovr_d = 1'b0;
   end

   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_CTRL: rdata = {29'b0, ctrl_q};
         ADDR_CMP:  rdata = 32'(cmp_q);
         ADDR_CNT:  rdata = 32'(cnt_q);
         ADDR_STAT: begin
            rdata[STAT_PEND] = pend_q;
            rdata[STAT_OVR]  = ovr_q;
         end
         default:   rdata = '0;
      endcase
   end

   assign dout_d = re ? rdata : dout_q;
   assign int_d  = pend_q && ctrl_q.ie;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ctrl_q  <= '0;
         cmp_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
         int_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         cmp_q   <= cmp_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         int_q   <= int_d;
         dout_q  <= dout_d;
      end
   end

   assign data_out = dout_q;
   assign INT      = int_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed plus randomized bench for timer_irq_ctrl against a cycle-level
// behavioural model of the register/interrupt rules.
module tb_timer_irq_ctrl;

   localparam int P = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] data_in = 32'd0;
   logic [31:0] data_out;
   logic        int_ack = 1'b0;
   logic        INT;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   timer_irq_ctrl #(.PRESCALE(P), .CNT_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .re       (re),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out),
      .int_ack  (int_ack),
      .INT      (INT)
   );

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_RUN, M_FIRED} mode_e;
   mode_e       m_mode;
   bit          m_en, m_per, m_ie, m_pend, m_ovr, m_int;
   logic [31:0] m_cmp, m_cnt, m_dout;
   int          m_phase;   // clocks spent in RUN since last restart, mod P

   task automatic model_reset();
      m_mode = M_IDLE; m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_ovr = 0;
      m_int = 0; m_cmp = 0; m_cnt = 0; m_dout = 0; m_phase = 0;
   endtask

   task automatic model_step(input bit w, input bit r, input logic [1:0] a,
                             input logic [31:0] d, input bit ack);
      bit tick, fire, ovr_set, cnt_w, ctl_w, cmp_w, st_w, was_run, now_run;
      longint nx;
      logic [31:0] n_cnt;
      mode_e n_mode;
      tick  = (m_mode == M_RUN) && (m_phase == P - 1);
      cnt_w = w && (a == 2'd2);
      ctl_w = w && (a == 2'd0);
      cmp_w = w && (a == 2'd1);
      st_w  = w && (a == 2'd3);
      if (r) begin
         case (a)
            2'd0:    m_dout = {29'b0, m_ie, m_per, m_en};
            2'd1:    m_dout = m_cmp;
            2'd2:    m_dout = m_cnt;
            default: m_dout = {30'b0, m_ovr, m_pend};
         endcase
      end
      m_int  = m_pend && m_ie;
      fire   = 0;
      n_cnt  = m_cnt;
      n_mode = m_mode;
      if (tick && !cnt_w) begin
         nx = longint'(m_cnt) + 1;
         if (nx == 64'h1_0000_0000) nx = 0;
         if (m_cmp != 0 && nx >= longint'(m_cmp)) begin
            fire = 1;
            if (m_per) n_cnt = 0;
            else begin n_cnt = 32'(nx); n_mode = M_FIRED; end
         end else begin
            n_cnt = 32'(nx);
         end
      end
      if (cnt_w) n_cnt = 0;
      if (ctl_w) begin
         if (m_mode == M_IDLE && d[0]) n_mode = M_RUN;
         else if (m_mode == M_RUN && !d[0]) n_mode = M_IDLE;
         else if (m_mode == M_FIRED) begin
            n_mode = d[0] ? M_RUN : M_IDLE;
            if (d[0]) n_cnt = 0;
         end
         m_en = d[0]; m_per = d[1]; m_ie = d[2];
      end
      if (cmp_w) m_cmp = d;
      was_run = (m_mode == M_RUN);
      now_run = (n_mode == M_RUN);
      if (cnt_w || was_run != now_run) m_phase = 0;
      else if (was_run) m_phase = (m_phase + 1) % P;
      ovr_set = fire && m_pend;
      if (fire) m_pend = 1;
      else if (ack || (st_w && d[0])) m_pend = 0;
      if (ovr_set) m_ovr = 1;
      else if (st_w && d[1]) m_ovr = 0;
      m_cnt  = n_cnt;
      m_mode = n_mode;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit w, input bit r, input logic [1:0] a,
                      input logic [31:0] d, input bit ack);
      we = w; re = r; addr = a; data_in = d; int_ack = ack;
      model_step(w, r, a, d, ack);
      @(posedge clk);
      #1;
      we = 0; re = 0; int_ack = 0;
      chk("int_model", {31'b0, INT}, {31'b0, m_int});
      chk("dout_model", data_out, m_dout);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 32'd0, 0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cyc(1, 0, a, d, 0);
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      cyc(0, 1, a, 32'd0, 0);
      v = data_out;
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic reset_pulse();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_int_now", {31'b0, INT}, 32'd0);
      chk("rst_dout_now", data_out, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_int(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (INT === 1'b1) break;
         cyc(0, 0, 2'd0, 32'd0, 0);
      end
      chk(tag, {31'b0, INT}, 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] v;
      logic [31:0] d;
      logic [1:0]  a;
      bit          w, r, ack;

      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: reset values
      for (int i = 0; i < 4; i++) begin
         rd(2'(i), v);
         chk("reset_read", v, 32'd0);
      end
      chk("reset_int", {31'b0, INT}, 32'd0);

      // 2: one-shot, fires on third tick and freezes
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h5);
      idle(12);
      chk("oneshot_int_lag", {31'b0, INT}, 32'd0);
      idle(1);
      chk("oneshot_int", {31'b0, INT}, 32'd1);
      rd(2'd2, v); chk("oneshot_count", v, 32'd3);
      idle(20);
      rd(2'd2, v); chk("oneshot_frozen", v, 32'd3);
      rd(2'd3, v); chk("oneshot_status", v, 32'd1);
      rd(2'd0, v); chk("oneshot_ctrl", v, 32'd5);

      // 3: periodic with ack, then overrun
      reset_pulse();
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h7);
      wait_int("per_first_int");
      cyc(0, 0, 2'd0, 32'd0, 1);
      idle(1);
      chk("per_ack_drop", {31'b0, INT}, 32'd0);
      wait_int("per_second_int");
      idle(10);
      wr(2'd0, 32'h6);
      rd(2'd3, v); chk("per_ovr", v, 32'd3);
      wr(2'd3, 32'h3);
      rd(2'd3, v); chk("per_w1c", v, 32'd0);
      idle(2);
      chk("per_int_clr", {31'b0, INT}, 32'd0);

      // 4: compare zero free-runs, then lowered compare fires next tick
      reset_pulse();
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h1);
      idle(40);
      rd(2'd2, v); chk("free_count", v, 32'd10);
      rd(2'd3, v); chk("free_nopend", v, 32'd0);
      wr(2'd1, 32'd5);
      idle(1);
      rd(2'd3, v); chk("lower_cmp_pend", v, 32'd1);
      rd(2'd2, v); chk("lower_cmp_count", v, 32'd11);

      // 5a: ack on the fire clock, set wins
      reset_pulse();
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h7);
      idle(7);
      cyc(0, 0, 2'd0, 32'd0, 1);
      rd(2'd3, v); chk("setwin_status", v, 32'd3);
      chk("setwin_int", {31'b0, INT}, 32'd1);

      // 5b: COUNT write on a tick clock
      reset_pulse();
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h5);
      idle(3);
      wr(2'd2, 32'd123);
      rd(2'd3, v); chk("cntwr_nopend", v, 32'd0);
      rd(2'd2, v); chk("cntwr_count", v, 32'd0);

      // 6: async reset mid-run with PEND set
      reset_pulse();
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h5);
      idle(5);
      rd(2'd3, v); chk("pre_rst_pend", v, 32'd1);
      reset_pulse();
      idle(20);
      rd(2'd2, v); chk("post_rst_count", v, 32'd0);
      rd(2'd3, v); chk("post_rst_status", v, 32'd0);
      rd(2'd0, v); chk("post_rst_ctrl", v, 32'd0);

      // Randomized traffic checked cycle by cycle against the model
      reset_pulse();
      for (int i = 0; i < 800; i++) begin
         w   = ($urandom_range(0, 99) < 25);
         a   = 2'($urandom_range(0, 3));
         d   = $urandom;
         case (a)
            2'd0: if ($urandom_range(0, 4) != 0) d[0] = 1'b1;
            2'd1: d = 32'($urandom_range(0, 6));
            2'd2: if ($urandom_range(0, 3) != 0) w = 0;
            default: ;
         endcase
         r   = bit'($urandom_range(0, 1));
         ack = ($urandom_range(0, 9) == 0);
         cyc(w, r, a, d, ack);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
